// File: rtl/multiplier_float_div_seq.sv
// Sequential floating-point divider: result = OP1 / OP2.
// Restoring radix-2 mantissa division producing one quotient bit per clock,
// followed by a single normalise/round/range-check cycle. The exponent bias,
// rounding rule and exception behaviour match the combinational float
// multiplier, so the two units can be chained in the same IIR datapath.
module multiplier_float_div_seq #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_exp = 8,
  parameter int WIDTH_mat = 23
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic             exce_in,
  output logic             busy,
  output logic             done,
  output logic             exce_out,
  output logic [WIDTH-1:0] result
);

  localparam int N    = WIDTH_mat + 3;     // quotient bits / DIV cycles
  localparam int MW   = WIDTH_mat + 1;     // mantissa width incl. hidden one
  localparam int EW   = WIDTH_exp + 2;     // signed exponent working width
  localparam int CW   = $clog2(N + 1);
  localparam int BIAS = 2 ** (WIDTH_exp - 1) - 1;

  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** WIDTH_exp - 2);
  localparam logic        [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RND
  } state_t;

  state_t                 state;
  logic                   sign_q;
  logic [MW-1:0]          mb;
  logic [MW:0]            rem;        // partial remainder, always < 2*mb
  logic [N-1:0]           quo;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   exp_diff;
  logic                   dz;
  logic                   zr;
  logic                   exc_q;

  // Exponent difference of the incoming operands, biased and sign-extended.
  logic signed [EW-1:0]   exp_in;
  assign exp_in = $signed({2'b00, OP1[WIDTH-2 -: WIDTH_exp]})
                - $signed({2'b00, OP2[WIDTH-2 -: WIDTH_exp]})
                + $signed(EW'(BIAS));

  // Trial subtraction; the extra top bit is the borrow (negative result).
  logic [MW+1:0] trial;
  assign trial = {1'b0, rem} - {2'b00, mb};

  logic [WIDTH_mat-1:0]   mant;
  logic                   rnd;
  logic                   sticky;
  logic signed [EW-1:0]   exp_n;
  logic [WIDTH_mat:0]     mant_inc;
  logic [WIDTH_mat-1:0]   mant_f;
  logic signed [EW-1:0]   exp_f;
  logic                   range_bad;
  logic                   exc_final;

  // Normalise the quotient, round (increment only on round & sticky) and range-check.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    mant   = '0;
    rnd    = 1'b0;
    sticky = 1'b0;
    exp_n  = exp_diff;
    if (quo[N-1]) begin
      mant   = quo[N-2:2];
      rnd    = quo[1];
      sticky = quo[0] | (|rem);
      exp_n  = exp_diff;
    end else begin
      mant   = quo[N-3:1];
      rnd    = quo[0];
      sticky = |rem;
      exp_n  = exp_diff - EW'(1);
    end
    mant_inc  = {1'b0, mant} + (WIDTH_mat + 1)'(rnd & sticky);
    exp_f     = exp_n + EW'(mant_inc[WIDTH_mat]);
    mant_f    = mant_inc[WIDTH_mat] ? '0 : mant_inc[WIDTH_mat-1:0];
    range_bad = (exp_f < EXP_MIN) || (exp_f > EXP_MAX);
    // A zero dividend yields signed zero; its meaningless exponent is not range-checked.
    exc_final = exc_q | dz | (~zr & range_bad);
  end

  // Control FSM and datapath registers: capture, iterate, round, report.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      exce_out <= 1'b0;
      result   <= '0;
      sign_q   <= 1'b0;
      mb       <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      exp_diff <= '0;
      dz       <= 1'b0;
      zr       <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= OP1[WIDTH-1] ^ OP2[WIDTH-1];
            mb       <= {1'b1, OP2[WIDTH_mat-1:0]};
            rem      <= {2'b01, OP1[WIDTH_mat-1:0]};
            exp_diff <= exp_in;
            dz       <= (OP2[WIDTH-2:0] == '0);
            zr       <= (OP1[WIDTH-2:0] == '0);
            exc_q    <= exce_in;
            quo      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          if (!trial[MW+1]) begin
            rem <= {trial[MW-1:0], 1'b0};
          end else begin
            rem <= {rem[MW-1:0], 1'b0};
          end
          quo <= {quo[N-2:0], ~trial[MW+1]};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= RND;
          end
        end
        RND: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (exc_final) begin
            exce_out <= 1'b1;
            result   <= '0;
          end else if (zr) begin
            exce_out <= 1'b0;
            result   <= {sign_q, {(WIDTH-1){1'b0}}};
          end else begin
            exce_out <= 1'b0;
            result   <= {sign_q, exp_f[WIDTH_exp-1:0], mant_f};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_float_div_seq.sv
// Directed self-checking bench for multiplier_float_div_seq (32-bit defaults).
module tb_multiplier_float_div_seq;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic        exce_in;
  logic        busy;
  logic        done;
  logic        exce_out;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  multiplier_float_div_seq dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .OP1      (OP1),
    .OP2      (OP2),
    .exce_in  (exce_in),
    .busy     (busy),
    .done     (done),
    .exce_out (exce_out),
    .result   (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One request: latency, busy length, result and exception flag.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ei, input logic [31:0] exp_res, input logic exp_exc);
    int lat;
    int busy_cnt;
    @(negedge CLK);
    OP1 = a; OP2 = b; exce_in = ei; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"},  lat, 27);
    check({tag, "_busy"}, busy_cnt, 27);
    check({tag, "_res"},  result, exp_res);
    check({tag, "_exc"},  {31'b0, exce_out}, {31'b0, exp_exc});
  endtask

  initial begin
    int lat;
    int stable_bad;
    int done_seen;
    RST = 1'b0; start = 1'b0; OP1 = '0; OP2 = '0; exce_in = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_exc",  {31'b0, exce_out}, 32'd0);
    check("rst_res",  result, 32'd0);
    RST = 1'b1;

    do_op("six_div_two",   32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
    do_op("one_third",     32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 1'b0);
    do_op("neg_7p5_2p5",   32'hC0F00000, 32'h40200000, 1'b0, 32'hC0400000, 1'b0);
    do_op("zero_div",      32'h00000000, 32'h40000000, 1'b0, 32'h00000000, 1'b0);
    do_op("neg_zero_div",  32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0);
    do_op("div_by_zero",   32'h40C00000, 32'h00000000, 1'b0, 32'h00000000, 1'b1);
    do_op("zero_by_zero",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
    do_op("overflow",      32'h7F000000, 32'h3E800000, 1'b0, 32'h00000000, 1'b1);
    do_op("underflow",     32'h00800000, 32'h7F000000, 1'b0, 32'h00000000, 1'b1);
    do_op("exp_max_ok",    32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 1'b0);
    do_op("exp_min_ok",    32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 1'b0);
    do_op("exce_in",       32'h40C00000, 32'h40000000, 1'b1, 32'h00000000, 1'b1);

    // Handshake: start held high throughout; operand changes while busy are ignored.
    @(negedge CLK);
    OP1 = 32'h40C00000; OP2 = 32'h40000000; exce_in = 1'b0; start = 1'b1;
    @(posedge CLK);
    #1;
    check("hs_busy_after_accept", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat == 5) begin
        OP1 = 32'h3F800000; OP2 = 32'h40400000;
      end
    end
    check("hs_first_lat", lat, 27);
    check("hs_first_res", result, 32'h40400000);
    lat = 0;
    stable_bad = 0;
    while (!done || lat == 0) begin
      if (lat >= 100) break;
      @(posedge CLK);
      #1;
      lat++;
      if (!done && result !== 32'h40400000) stable_bad++;
      if (lat == 1) begin
        check("hs_accept_on_done", {31'b0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    check("hs_second_lat", lat, 28);
    check("hs_result_stable", stable_bad, 0);
    check("hs_second_res", result, 32'h3EAAAAAB);

    // Asynchronous reset mid-division (counter = 10).
    @(negedge CLK);
    OP1 = 32'h40C00000; OP2 = 32'h40000000; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_res",  result, 32'd0);
    check("arst_exc",  {31'b0, exce_out}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge CLK);
      #1;
      if (done) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    do_op("after_reset", 32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
